keypad_scan_hist: RTL and testbench
===================================

# keypad_scan_hist

Parametrised matrix-keypad scanner with per-column settle, press/release debounce, optional typematic auto-repeat and a HIST_DEPTH-deep key history. It generalises the 4x4 two-key keypad FSM to arbitrary rows, columns and history depth. It sits between the keypad pins and the display or readout logic, which consumes `key_hist` directly.

## Interface
- NROWS, 4: keypad rows (≥1)
- NCOLS, 4: keypad columns (≥2)
- HIST_DEPTH, 2: keys retained; index 0 newest
- SCAN_CYCLES, 16: column dwell before row sample (≥4)
- DEBOUNCE_CYCLES, 1000: stable cycles for press and for release (≥2)
- HEX_MAP, 1: 1 = hex legend (needs 4x4); 0 = code row*NCOLS+col
- REPEAT_EN, 0: 1 = auto-repeat while held
- REPEAT_DELAY, 50000: held cycles before first repeat
- REPEAT_PERIOD, 10000: cycles between repeats
- KEY_W, derived: 4 if HEX_MAP, else $clog2(NROWS*NCOLS)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rows  in  NROWS  active-low row sense; external pull-ups hold idle rows at 1
- cols  out (tri)  NCOLS  scanned column driven 0; all others 'z'
- key_hist  out  HIST_DEPTH×KEY_W  [0] = newest accepted key, [1] = previous, …
- key_valid  out  1  one-cycle pulse when a key is pushed into history
- key_held  out  1  high while an accepted key is still pressed

## Operation
- Rows pass through a 2-FF synchroniser; all decisions use the synchronised value `rs`.
- Hex legend, by row then column: row 0 = 1 2 3 A; row 1 = 4 5 6 B; row 2 = 7 8 9 C; row 3 = E 0 F D.
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN: drive column `col`; at the last dwell cycle, sample `rs`.
  - No low row: advance `col`, wrapping NCOLS-1 to 0.
  - Exactly one low row: latch row and col, go to PRESS_DB.
  - More than one low row: treat as ghost/invalid and advance `col`.
- PRESS_DB: keep the column driven; count cycles where `rs` equals the latched pattern.
  - Any mismatch: go to SCAN at the next column; nothing is recorded.
  - Count reaches DEBOUNCE_CYCLES: shift history (hist[i] ← hist[i-1], hist[0] ← code), pulse `key_valid`, go to HELD.
- HELD: keep the column driven; `key_held` = 1.
  - Latched row reads high: go to RELEASE_DB.
  - REPEAT_EN: after REPEAT_DELAY held cycles, push the same code again every REPEAT_PERIOD cycles, each push with a `key_valid` pulse.
- RELEASE_DB: row must read high for DEBOUNCE_CYCLES consecutive cycles.
  - Any low cycle: counter clears and stays in RELEASE_DB; no new push and no repeat.
  - Count complete: go to SCAN at the next column.
- Other keys pressed while in HELD/RELEASE_DB are ignored. They are detected only after release completes and the scan reaches them.
- HEX_MAP=1 with NROWS or NCOLS ≠ 4 is an elaboration error.

## Timing
- Reset values: state SCAN, col 0, `cols` = 0 on bit 0 and 'z' elsewhere, `key_hist` all 0, `key_valid` 0, `key_held` 0, all counters 0.
- Reset asserted mid-operation returns everything to reset values immediately; a key held across reset deassertion is re-detected and debounced from scratch.
- Press-to-`key_valid` latency: at most NCOLS·SCAN_CYCLES + 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- `key_hist` updates on the same edge that raises `key_valid`.
- Consecutive pushes are at least DEBOUNCE_CYCLES apart, or REPEAT_PERIOD apart in repeat mode.
- Counters are sized by $clog2 of their maximum parameter and saturate; they never wrap.

## Structure
- keypad_pkg: state enum, hex legend lookup function, KEY_W computation function.
- Sub-module sync_2ff: parametrised-width two-flop synchroniser, reset to all-1s (idle rows).
- Top: FSM, column counter, dwell/debounce/repeat counters, history shift register, tri-state column drivers.

## Test plan
All tests use defaults and a 10 ns clock, with a tranif-switch keypad model and pulled-up rows.
- Reset release, no key pressed → `key_hist` = {0,0}, `key_valid` never pulses, `cols` walks 1110→1101→1011→0111 (z for 1) every 16 cycles.
- Press r1c2 held 50 µs → `key_hist[1]` = 0, `key_hist[0]` = 6, exactly one `key_valid` pulse within the latency bound, `key_held` = 1.
- Release, then press r2c1 → `key_hist` = {6,8}.
- 10-cycle glitch on r0c0, then 2-cycle bounces during release → no push on the glitch; exactly one push per genuine press.
- Hold r1c1, press r3c3 too, release r1c1, release r3c3 → hist receives 5 then D, in order; no extra pushes.
- REPEAT_EN=1, REPEAT_DELAY=200, REPEAT_PERIOD=50, hold r0c3 for 500 cycles after accept → pushes A at accept, accept+200, +250, +300, … ; assert reset mid-hold → hist clears to 0 at once.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner: FSM states,
// hex legend lookup and key-code width derivation.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  // Key code width: the hex legend always fits a nibble, otherwise the
  // linear code row*NCOLS+col needs enough bits for every key.
  function automatic int calc_key_w(input int hex_map, input int nkeys);
    return (hex_map != 0) ? 4 : ((nkeys > 1) ? $clog2(nkeys) : 1);
  endfunction

  function automatic logic [3:0] hex_legend(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous row inputs; resets to all-ones
// so an idle (pulled-up) keypad reads as "no key" straight out of reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_hist.sv
// Matrix keypad scanner: column walk with settle dwell, press/release debounce,
// optional typematic repeat and a shift-register history of accepted keys.
module keypad_scan_hist
  import keypad_pkg::*;
#(
  parameter int NROWS           = 4,
  parameter int NCOLS           = 4,
  parameter int HIST_DEPTH      = 2,
  parameter int SCAN_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int HEX_MAP         = 1,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50000,
  parameter int REPEAT_PERIOD   = 10000,
  localparam int KEY_W          = calc_key_w(HEX_MAP, NROWS * NCOLS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NROWS-1:0]                    rows,
  output tri   [NCOLS-1:0]                    cols,
  output logic [HIST_DEPTH-1:0][KEY_W-1:0]    key_hist,
  output logic                                key_valid,
  output logic                                key_held
);

  localparam int RW      = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int CW      = $clog2(NCOLS);
  localparam int DWELL_W = $clog2(SCAN_CYCLES);
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  localparam logic [CW-1:0]      COL_LAST   = CW'(NCOLS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0]   REP_FIRST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0]   REP_NEXT   = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0]   REP_SAT    = '1;

  if (HEX_MAP != 0 && (NROWS != 4 || NCOLS != 4)) begin : g_bad_hex
    $error("keypad_scan_hist: HEX_MAP=1 requires a 4x4 keypad");
  end

  state_t             state;
  logic [NROWS-1:0]   rs;
  logic [NROWS-1:0]   pattern;
  logic [CW-1:0]      col;
  logic [CW-1:0]      col_next;
  logic [RW-1:0]      row;
  logic [RW-1:0]      low_row;
  logic               one_low;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DB_W-1:0]    db_cnt;
  logic [REP_W-1:0]   rep_cnt;
  logic               rep_first;
  logic [KEY_W-1:0]   code;
  logic               do_push;

  sync_2ff #(.W(NROWS)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rows),
    .q    (rs)
  );

  // Only the scanned column is pulled low; every other column floats.
  for (genvar c = 0; c < NCOLS; c++) begin : g_col
    assign cols[c] = (col == CW'(c)) ? 1'b0 : 1'bz;
  end

  assign col_next = (col == COL_LAST) ? '0 : col + 1'b1;
  assign one_low  = ($countones(~rs) == 1);

  // NOTE: every combinational output gets a default before any conditional
  // update, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    low_row = '0;
    for (int r = 0; r < NROWS; r++) begin
      if (!rs[r]) low_row = RW'(r);
    end
  end

  always_comb begin
    if (HEX_MAP != 0) code = KEY_W'(hex_legend(2'(row), 2'(col)));
    else              code = KEY_W'(int'(row) * NCOLS + int'(col));
  end

  // A push is either the final matching press-debounce cycle or a repeat
  // tick while the latched row is still held low.
  always_comb begin
    do_push = 1'b0;
    if (state == PRESS_DB && rs == pattern && db_cnt == DB_LAST) do_push = 1'b1;
    if (state == HELD && !rs[row] && REPEAT_EN != 0 &&
        rep_cnt == (rep_first ? REP_FIRST : REP_NEXT)) do_push = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col       <= '0;
      row       <= '0;
      pattern   <= '1;
      dwell_cnt <= '0;
      db_cnt    <= '0;
      rep_cnt   <= '0;
      rep_first <= 1'b1;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= do_push;
      case (state)
        SCAN: begin
          if (dwell_cnt != DWELL_LAST) begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end else begin
            dwell_cnt <= '0;
            if (one_low) begin
              row     <= low_row;
              pattern <= rs;
              db_cnt  <= '0;
              state   <= PRESS_DB;
            end else begin
              col <= col_next;
            end
          end
        end
        PRESS_DB: begin
          if (rs != pattern) begin
            db_cnt <= '0;
            col    <= col_next;
            state  <= SCAN;
          end else if (do_push) begin
            db_cnt    <= '0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
            key_held  <= 1'b1;
            state     <= HELD;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        HELD: begin
          if (rs[row]) begin
            key_held <= 1'b0;
            db_cnt   <= '0;
            state    <= RELEASE_DB;
          end else if (do_push) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else if (rep_cnt != REP_SAT) begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        RELEASE_DB: begin
          if (!rs[row]) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            col    <= col_next;
            state  <= SCAN;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  // NOTE: the history is architectural state read directly by the display,
  // so unlike a scratch memory it must be cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_hist <= '0;
    end else if (do_push) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) key_hist[i] <= key_hist[i-1];
      key_hist[0] <= code;
    end
  end

endmodule

// File: tb/tb_keypad_scan_hist.sv
// Self-checking bench for keypad_scan_hist: behavioural keypad, expected-push
// scoreboard, per-cycle history compare and a repeat-mode instance.
module tb_keypad_scan_hist;

  localparam int DEB     = 1000;
  localparam int SCAN    = 16;
  localparam int NC      = 4;
  localparam int LAT_MAX = NC * SCAN + 2 + DEB + 1;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_r = 1'b1;
  always #5 clk = ~clk;

  logic [3:0][3:0] pressed   = '0;
  logic [3:0][3:0] pressed_r = '0;
  logic [3:0]      rows, rows_r;
  wire  [3:0]      cols_w, cols_r;
  logic [1:0][3:0] hist, hist_r;
  logic            valid, held, valid_r, held_r;

  for (genvar i = 0; i < 4; i++) begin : g_pu
    pullup (cols_w[i]);
    pullup (cols_r[i]);
  end

  // Switch-matrix keypad: a pressed key shorts its row to its column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      rows[r]   = 1'b1;
      rows_r[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (pressed[r][c]   && cols_w[c] == 1'b0) rows[r]   = 1'b0;
        if (pressed_r[r][c] && cols_r[c] == 1'b0) rows_r[r] = 1'b0;
      end
    end
  end

  keypad_scan_hist dut (
    .clk      (clk),
    .reset    (rst),
    .rows     (rows),
    .cols     (cols_w),
    .key_hist (hist),
    .key_valid(valid),
    .key_held (held)
  );

  keypad_scan_hist #(
    .REPEAT_EN    (1),
    .REPEAT_DELAY (200),
    .REPEAT_PERIOD(50)
  ) dut_rep (
    .clk      (clk),
    .reset    (rst_r),
    .rows     (rows_r),
    .cols     (cols_r),
    .key_hist (hist_r),
    .key_valid(valid_r),
    .key_held (held_r)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the default instance: history advances only by codes the bench
  // expects; any pulse with nothing expected is an error.
  logic [1:0][3:0] m_hist = '0;
  logic [3:0]      exp_q[$];
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_hist = '0;
    end else begin
      if (valid) begin
        if (exp_q.size() == 0) check("unexpected_push", 32'(valid), 32'd0);
        else m_hist = {m_hist[0], exp_q.pop_front()};
      end
      check("hist_vs_model", 32'(hist), 32'(m_hist));
    end
  end

  // Model of the repeat instance: only key A is ever pressed there.
  logic [1:0][3:0] m_rep = '0;
  int              rep_t[$];
  initial forever begin
    @(negedge clk);
    if (rst_r) begin
      m_rep = '0;
    end else begin
      if (valid_r) begin
        m_rep = {m_rep[0], 4'hA};
        rep_t.push_back(cyc);
      end
      check("rep_hist_vs_model", 32'(hist_r), 32'(m_rep));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press_expect(input int r, input int c, input logic [3:0] code);
    int n = 0;
    exp_q.push_back(code);
    pressed[r][c] = 1'b1;
    while (exp_q.size() != 0 && n < LAT_MAX) begin
      tick();
      n++;
    end
    check("press_within_latency", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    check("held_after_accept", 32'(held), 32'd1);
  endtask

  task automatic release_key(input int r, input int c);
    pressed[r][c] = 1'b0;
    repeat (DEB + 20) tick();
    check("held_after_release", 32'(held), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    check("reset_hist", 32'(hist), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_held", 32'(held), 32'd0);
    check("reset_cols", 32'(cols_w), 32'b1110);
    repeat (3) tick();
    rst = 1'b0;

    // Idle column walk, one column per 16-cycle dwell.
    repeat (8) tick();
    check("walk_c0", 32'(cols_w), 32'b1110);
    repeat (16) tick();
    check("walk_c1", 32'(cols_w), 32'b1101);
    repeat (16) tick();
    check("walk_c2", 32'(cols_w), 32'b1011);
    repeat (16) tick();
    check("walk_c3", 32'(cols_w), 32'b0111);
    repeat (16) tick();
    check("walk_wrap", 32'(cols_w), 32'b1110);
    check("idle_hist", 32'(hist), 32'd0);

    // r1c2 held for about 50 us.
    press_expect(1, 2, 4'h6);
    check("hist_lit_0_6", 32'(hist), 32'({4'h0, 4'h6}));
    repeat (4000) tick();
    check("held_long", 32'(held), 32'd1);
    release_key(1, 2);

    press_expect(2, 1, 4'h8);
    check("hist_lit_6_8", 32'(hist), 32'({4'h6, 4'h8}));
    release_key(2, 1);

    // 10-cycle glitch on r0c0 must not be accepted.
    pressed[0][0] = 1'b1;
    repeat (10) tick();
    pressed[0][0] = 1'b0;
    repeat (100) tick();
    check("glitch_held", 32'(held), 32'd0);
    check("glitch_hist", 32'(hist), 32'({4'h6, 4'h8}));

    // Genuine r0c0 press with bouncy release.
    press_expect(0, 0, 4'h1);
    check("hist_lit_8_1", 32'(hist), 32'({4'h8, 4'h1}));
    for (int b = 0; b < 3; b++) begin
      pressed[0][0] = 1'b0;
      repeat (2) tick();
      pressed[0][0] = 1'b1;
      repeat (2) tick();
    end
    release_key(0, 0);

    // Second key pressed while the first is held is taken only after release.
    press_expect(1, 1, 4'h5);
    pressed[3][3] = 1'b1;
    repeat (100) tick();
    check("two_key_held", 32'(held), 32'd1);
    check("two_key_hist", 32'(hist), 32'({4'h1, 4'h5}));
    exp_q.push_back(4'hD);
    pressed[1][1] = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 2 * DEB + NC * SCAN + 40) begin
      tick();
      n++;
    end
    check("second_key_pushed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check("hist_lit_5_D", 32'(hist), 32'({4'h5, 4'hD}));
    release_key(3, 3);

    // Repeat instance: A at accept, +200, then every 50.
    rst_r = 1'b0;
    pressed_r[0][3] = 1'b1;
    n = 0;
    while (rep_t.size() == 0 && n < LAT_MAX) begin
      tick();
      n++;
    end
    check("rep_accept", 32'(rep_t.size()), 32'd1);
    repeat (520) tick();
    check("rep_count", 32'(rep_t.size()), 32'd8);
    for (int i = 1; i < 8; i++) begin
      if (i < rep_t.size())
        check("rep_offset", 32'(rep_t[i] - rep_t[0]), 32'(200 + 50 * (i - 1)));
    end
    check("rep_hist_lit", 32'(hist_r), 32'({4'hA, 4'hA}));
    check("rep_held", 32'(held_r), 32'd1);

    // Asynchronous reset mid-hold clears immediately, without a clock edge.
    #2;
    rst_r = 1'b1;
    #1;
    check("rep_reset_hist", 32'(hist_r), 32'd0);
    check("rep_reset_valid", 32'(valid_r), 32'd0);
    check("rep_reset_held", 32'(held_r), 32'd0);
    check("rep_reset_cols", 32'(cols_r), 32'b1110);
    repeat (3) tick();
    rst_r = 1'b0;
    rep_t.delete();
    n = 0;
    while (rep_t.size() == 0 && n < LAT_MAX) begin
      tick();
      n++;
    end
    check("rep_redetect", 32'(rep_t.size()), 32'd1);
    check("rep_redetect_hist", 32'(hist_r), 32'({4'h0, 4'hA}));
    pressed_r[0][3] = 1'b0;
    repeat (DEB + 20) tick();
    check("rep_released", 32'(held_r), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
